// File: rtl/reservation_station_if.sv
// Dispatch and issue buses of the ALU reservation station.
// master = the reservation station; slave = the dispatcher/ALU side.
interface reservation_station_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int OP_WIDTH   = 6,
  parameter int ROB_WIDTH  = 4
);
  logic                  valid_dp_in;
  logic [ADDR_WIDTH-1:0] pc_dp_in;
  logic [OP_WIDTH-1:0]   opcode_dp_in;
  logic [DATA_WIDTH-1:0] vj_dp_in;
  logic [DATA_WIDTH-1:0] vk_dp_in;
  logic [DATA_WIDTH-1:0] imm_dp_in;
  logic                  qj_busy_dp_in;
  logic                  qk_busy_dp_in;
  logic [ROB_WIDTH-1:0]  qj_dp_in;
  logic [ROB_WIDTH-1:0]  qk_dp_in;
  logic [ROB_WIDTH-1:0]  rob_id_dp_in;
  logic                  full_dp_out;
  logic                  idle_alu_in;
  logic                  rdy_rs_out;
  logic [ADDR_WIDTH-1:0] pc_rs_out;
  logic [OP_WIDTH-1:0]   opcode_rs_out;
  logic [DATA_WIDTH-1:0] vj_rs_out;
  logic [DATA_WIDTH-1:0] vk_rs_out;
  logic [DATA_WIDTH-1:0] imm_rs_out;
  logic [ROB_WIDTH-1:0]  rob_id_rs_out;

  modport master (
    input  valid_dp_in, pc_dp_in, opcode_dp_in, vj_dp_in, vk_dp_in, imm_dp_in,
           qj_busy_dp_in, qk_busy_dp_in, qj_dp_in, qk_dp_in, rob_id_dp_in, idle_alu_in,
    output full_dp_out, rdy_rs_out, pc_rs_out, opcode_rs_out, vj_rs_out, vk_rs_out,
           imm_rs_out, rob_id_rs_out
  );

  modport slave (
    output valid_dp_in, pc_dp_in, opcode_dp_in, vj_dp_in, vk_dp_in, imm_dp_in,
           qj_busy_dp_in, qk_busy_dp_in, qj_dp_in, qk_dp_in, rob_id_dp_in, idle_alu_in,
    input  full_dp_out, rdy_rs_out, pc_rs_out, opcode_rs_out, vj_rs_out, vk_rs_out,
           imm_rs_out, rob_id_rs_out
  );
endinterface

// File: rtl/reservation_station.sv
// ALU reservation station: holds dispatched instructions, snoops both CDBs, issues one per cycle.
// Define RS_AGE_SELECT_EN to issue the oldest ready entry instead of the lowest-index one.
module reservation_station #(
  parameter int RS_SIZE    = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int OP_WIDTH   = 6,
  parameter int ROB_WIDTH  = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  reservation_station_if.master rs_if,
  input  logic                  rdy_a_cdb_in,
  input  logic [DATA_WIDTH-1:0] result_a_cdb_in,
  input  logic [ROB_WIDTH-1:0]  rob_id_a_cdb_in,
  input  logic                  rdy_l_cdb_in,
  input  logic [DATA_WIDTH-1:0] result_l_cdb_in,
  input  logic [ROB_WIDTH-1:0]  rob_id_l_cdb_in
);
  localparam int IDX_W = $clog2(RS_SIZE);

  typedef struct packed {
    logic                  qj_busy;
    logic                  qk_busy;
    logic [ROB_WIDTH-1:0]  qj;
    logic [ROB_WIDTH-1:0]  qk;
    logic [DATA_WIDTH-1:0] vj;
    logic [DATA_WIDTH-1:0] vk;
    logic [DATA_WIDTH-1:0] imm;
    logic [ADDR_WIDTH-1:0] pc;
    logic [OP_WIDTH-1:0]   opcode;
    logic [ROB_WIDTH-1:0]  rob_id;
  } entry_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [OP_WIDTH-1:0]   opcode;
    logic [DATA_WIDTH-1:0] vj;
    logic [DATA_WIDTH-1:0] vk;
    logic [DATA_WIDTH-1:0] imm;
    logic [ROB_WIDTH-1:0]  rob_id;
  } issue_t;

  logic [RS_SIZE-1:0] busy_q, busy_d;
  entry_t             ent_q [RS_SIZE];
  entry_t             ent_d [RS_SIZE];
  issue_t             iss_q, iss_d;
  logic               rdy_rs_q, rdy_rs_d;

  logic               full;
  logic [RS_SIZE-1:0] ready;
  logic               sel_found;
  logic [IDX_W-1:0]   free_idx, sel_idx;
  entry_t             dp_ent;

`ifdef RS_AGE_SELECT_EN
  localparam int AGE_W = IDX_W + 1;
  logic [AGE_W-1:0] age_q [RS_SIZE];
  logic [AGE_W-1:0] age_d [RS_SIZE];
  logic [AGE_W-1:0] seq_q, seq_d;
  logic [AGE_W-1:0] best_age, age_diff;
`endif

  // Resolve a pending operand against both CDBs; the ALU bus has priority.
  function automatic logic [DATA_WIDTH:0] snoop(input logic pend,
                                                input logic [ROB_WIDTH-1:0] tag,
                                                input logic [DATA_WIDTH-1:0] val);
    if (pend && rdy_a_cdb_in && tag == rob_id_a_cdb_in) return {1'b0, result_a_cdb_in};
    if (pend && rdy_l_cdb_in && tag == rob_id_l_cdb_in) return {1'b0, result_l_cdb_in};
    return {pend, val};
  endfunction

  always_comb begin
    full      = &busy_q;
    ready     = '0;
    free_idx  = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++)
      ready[i] = busy_q[i] & ~ent_q[i].qj_busy & ~ent_q[i].qk_busy;
    for (int unsigned i = RS_SIZE; i > 0; i--)
      if (!busy_q[i-1]) free_idx = IDX_W'(i - 1);
`ifdef RS_AGE_SELECT_EN
    // Modular age compare: a negative difference means the candidate is older.
    best_age = '0;
    age_diff = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      age_diff = age_q[i] - best_age;
      if (ready[i] && (!sel_found || age_diff[AGE_W-1])) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        best_age  = age_q[i];
      end
    end
`else
    for (int unsigned i = RS_SIZE; i > 0; i--)
      if (ready[i-1]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i - 1);
      end
`endif
  end

  always_comb begin
    busy_d   = busy_q;
    ent_d    = ent_q;
    iss_d    = iss_q;
    rdy_rs_d = 1'b0;
`ifdef RS_AGE_SELECT_EN
    age_d    = age_q;
    seq_d    = seq_q;
`endif
    dp_ent = '{qj_busy: 1'b0, qk_busy: 1'b0, qj: rs_if.qj_dp_in, qk: rs_if.qk_dp_in,
               vj: '0, vk: '0, imm: rs_if.imm_dp_in, pc: rs_if.pc_dp_in,
               opcode: rs_if.opcode_dp_in, rob_id: rs_if.rob_id_dp_in};
    {dp_ent.qj_busy, dp_ent.vj} = snoop(rs_if.qj_busy_dp_in, rs_if.qj_dp_in, rs_if.vj_dp_in);
    {dp_ent.qk_busy, dp_ent.vk} = snoop(rs_if.qk_busy_dp_in, rs_if.qk_dp_in, rs_if.vk_dp_in);

    if (flush_in) begin
      busy_d = '0;
    end else if (rdy_in) begin
      for (int unsigned i = 0; i < RS_SIZE; i++)
        if (busy_q[i]) begin
          {ent_d[i].qj_busy, ent_d[i].vj} = snoop(ent_q[i].qj_busy, ent_q[i].qj, ent_q[i].vj);
          {ent_d[i].qk_busy, ent_d[i].vk} = snoop(ent_q[i].qk_busy, ent_q[i].qk, ent_q[i].vk);
        end
      if (sel_found && rs_if.idle_alu_in) begin
        iss_d = '{pc: ent_q[sel_idx].pc, opcode: ent_q[sel_idx].opcode,
                  vj: ent_q[sel_idx].vj, vk: ent_q[sel_idx].vk,
                  imm: ent_q[sel_idx].imm, rob_id: ent_q[sel_idx].rob_id};
        rdy_rs_d         = 1'b1;
        busy_d[sel_idx]  = 1'b0;
      end
      // Free slot is taken from pre-edge occupancy, so a slot freed now is reused next edge.
      if (rs_if.valid_dp_in && !full) begin
        busy_d[free_idx] = 1'b1;
        ent_d[free_idx]  = dp_ent;
`ifdef RS_AGE_SELECT_EN
        age_d[free_idx]  = seq_q;
        seq_d            = seq_q + 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q   <= '0;
      ent_q    <= '{default: '0};
      iss_q    <= '0;
      rdy_rs_q <= 1'b0;
`ifdef RS_AGE_SELECT_EN
      age_q    <= '{default: '0};
      seq_q    <= '0;
`endif
    end else begin
      busy_q   <= busy_d;
      ent_q    <= ent_d;
      iss_q    <= iss_d;
      rdy_rs_q <= rdy_rs_d;
`ifdef RS_AGE_SELECT_EN
      age_q    <= age_d;
      seq_q    <= seq_d;
`endif
    end
  end

  assign rs_if.full_dp_out   = full;
  assign rs_if.rdy_rs_out    = rdy_rs_q;
  assign rs_if.pc_rs_out     = iss_q.pc;
  assign rs_if.opcode_rs_out = iss_q.opcode;
  assign rs_if.vj_rs_out     = iss_q.vj;
  assign rs_if.vk_rs_out     = iss_q.vk;
  assign rs_if.imm_rs_out    = iss_q.imm;
  assign rs_if.rob_id_rs_out = iss_q.rob_id;
endmodule

// File: doc/reservation_station.md
# reservation_station

Out-of-order issue buffer feeding the ALU in the Tomasulo RISC-V core. Accepts decoded instructions from the dispatcher, holds them until both source operands are available, snoops the ALU and LSB common data buses for pending operands, and issues one ready instruction per cycle to the ALU over the `rdy_rs`/`pc_rs`/`opcode_rs`/`vj_rs`/`vk_rs`/`imm_rs`/`rob_id_rs` interface. It is the issuing end of the interface the ALU consumes.

## Interface
- `RS_SIZE`, 8, number of entries (power of two, 2..16)
- `DATA_WIDTH`, 32, operand/immediate width
- `ADDR_WIDTH`, 32, PC width
- `OP_WIDTH`, 6, internal opcode width
- `ROB_WIDTH`, 4, ROB tag width
- `clk_in`  in  1  clock; all state updates on the rising edge
- `rst_n_in`  in  1  reset, asynchronous, active-low
- `rdy_in`  in  1  global enable; low = pause
- `flush_in`  in  1  misprediction clear from the ROB
- `valid_dp_in`  in  1  dispatch request
- `pc_dp_in`  in  ADDR_WIDTH  instruction PC
- `opcode_dp_in`  in  OP_WIDTH  opcode
- `vj_dp_in`, `vk_dp_in`, `imm_dp_in`  in  DATA_WIDTH  operand values / immediate
- `qj_busy_dp_in`, `qk_busy_dp_in`  in  1  operand pending
- `qj_dp_in`, `qk_dp_in`  in  ROB_WIDTH  producer tag when pending
- `rob_id_dp_in`  in  ROB_WIDTH  destination tag
- `full_dp_out`  out  1  no free entry (combinational from state)
- `idle_alu_in`  in  1  ALU can accept this cycle
- `rdy_rs_out`  out  1  issue valid (registered)
- `pc_rs_out`, `opcode_rs_out`, `vj_rs_out`, `vk_rs_out`, `imm_rs_out`, `rob_id_rs_out`  out  matching widths  issued instruction fields (registered)
- `rdy_a_cdb_in`, `result_a_cdb_in`, `rob_id_a_cdb_in`  in  1/DATA_WIDTH/ROB_WIDTH  ALU CDB
- `rdy_l_cdb_in`, `result_l_cdb_in`, `rob_id_l_cdb_in`  in  1/DATA_WIDTH/ROB_WIDTH  LSB CDB

## Operation
- Entry state: `busy`, `qj_busy`, `qk_busy`, `qj`, `qk`, `vj`, `vk`, `imm`, `pc`, `opcode`, `rob_id`.
- Priority per edge: reset > flush > `rdy_in` low > normal.
- Dispatch: if `valid_dp_in` and not `full_dp_out`, write to the lowest-index free entry. Dispatch while full is ignored.
- Dispatch bypass: a pending operand whose tag matches a CDB valid in the same cycle is stored as ready, with the CDB value.
- Wake-up: for every busy entry, a pending `qj`/`qk` matching `rob_id_a_cdb_in` (when `rdy_a_cdb_in`) or `rob_id_l_cdb_in` (when `rdy_l_cdb_in`) captures the result and clears its busy bit. If both CDBs match, the ALU CDB wins.
- Select: among entries that are busy with both q bits clear in the pre-edge state, pick one (see Configuration). If one exists and `idle_alu_in` is high, register its fields onto the `*_rs_out` outputs, set `rdy_rs_out`=1, and free the entry at the same edge. Otherwise `rdy_rs_out`=0.
- A freed slot is reusable by dispatch at the following edge, not the same edge.
- Flush: clear all `busy` bits and `rdy_rs_out`; ignore dispatch and CDB that cycle.
- `rdy_in` low: all state holds, and `rdy_rs_out` is cleared so the entry is not re-issued.

## Timing
- Reset: all `busy`=0, `rdy_rs_out`=0, every `*_rs_out` field=0, `full_dp_out`=0.
- Dispatch with both operands ready at edge D: `rdy_rs_out` high for the cycle after edge D+1 (latency 1).
- Operand woken at edge W: issue at edge W+1.
- `rdy_rs_out` is a single-cycle pulse per issued instruction. There is no back-pressure beyond `idle_alu_in`.
- `full_dp_out` rises in the cycle after the edge that fills the last entry.

## Configuration
- `RS_AGE_SELECT_EN` defined: each entry holds a dispatch sequence number (a `$clog2(RS_SIZE)+1`-bit counter, compared modulo). Select picks the oldest ready entry.
- Not defined: select picks the lowest-index ready entry. There is no age storage.

## Test plan
- Reset mid-operation: with 3 busy entries, pull `rst_n_in` low asynchronously -> `rdy_rs_out`=0 and `full_dp_out`=0 immediately, and no issue after release.
- Dispatch ADD with vj=5, vk=7 ready, rob_id=3 at edge 1 -> at edge 2 `rdy_rs_out`=1, `vj_rs_out`=5, `vk_rs_out`=7, `rob_id_rs_out`=3. At edge 3 `rdy_rs_out`=0.
- Dispatch with qj=2 pending, then ALU CDB rob_id=2 result=0x1234 two cycles later -> issue with `vj_rs_out`=0x1234 one edge after the broadcast. Also: the same broadcast arriving in the dispatch cycle -> issue at the next edge.
- Fill all 8 entries with pending operands -> `full_dp_out`=1 and a 9th dispatch is dropped. Wake entry 5 -> it issues, and `full_dp_out`=0 the cycle after.
- Two ready entries with `RS_AGE_SELECT_EN`, older entry at index 6 and younger at index 1 -> index 6 issues first. Without the macro, index 1 issues first.
- `flush_in` with 4 busy entries plus a simultaneous dispatch -> all entries cleared, the dispatch is dropped, and `rdy_rs_out`=0 for the following cycles.
